// File: rtl/alu_op_issue.sv
// Purpose: decode 16-bit instruction words into {ALU_op, ALU_funct} and issue them to ALU control through a small op FIFO.
// Latency: an op accepted into an empty FIFO is presented one cycle later; there is no combinational path from instr to ALU_op.
// Backpressure: instr_ready drops when the FIFO is full or the block has halted; it is built from registered state only.
//
// Ports:
//   clk, rst_n              single clock, asynchronous active-low reset
//   instr_valid/instr_ready instruction handshake; instr[15:11] opcode, instr[1:0] function
//   op_valid/op_ready       issue handshake; ALU_op / ALU_funct driven from the FIFO head, zero when idle
//   halted                  HALT has been accepted; only reset restarts intake
//   illegal                 sticky: an unsupported opcode was accepted and dropped
//   issue_cnt               wrapping count of ops consumed downstream

// Purpose: generic first-word-fall-through FIFO used for the op buffer.
// Latency: a pushed word is visible at rdata on the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; full/empty are registered-state decodes.
module alu_op_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: stale entries are never observable while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module alu_op_issue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       ALU_op,
  output logic [1:0]       ALU_funct,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt
);
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nxt;
  logic        ready_en;

  logic [4:0]  opcode;
  logic [1:0]  funct_in;
  logic        op_supported;
  logic        op_is_rfmt;
  logic        op_is_halt;
  logic [6:0]  push_dat;

  logic        accept;
  logic        push;
  logic        pop;
  logic [6:0]  head_dat;
  logic        fifo_empty;
  logic        fifo_full;

  // Middle instruction bits carry no meaning for issue.
  logic        unused_instr_bits;
  assign unused_instr_bits = ^instr[10:2];

  assign opcode   = instr[15:11];
  assign funct_in = instr[1:0];

  // Opcode decode: 00000 (HALT), 010xx, 10xxx and 11xxx are supported.
  always_comb begin
    op_supported = 1'b0;
    op_is_rfmt   = 1'b0;
    op_is_halt   = 1'b0;
    if (opcode == 5'b00000) begin
      op_supported = 1'b1;
      op_is_halt   = 1'b1;
    end else if (opcode[4:2] == 3'b010) begin
      op_supported = 1'b1;
    end else if (opcode[4] == 1'b1) begin
      op_supported = 1'b1;
    end
    // Only the two R-format opcodes forward the function field.
    if (opcode[4:1] == 4'b1101) op_is_rfmt = 1'b1;
  end

  assign push_dat = {opcode, (op_is_rfmt ? funct_in : 2'b00)};

  assign accept = instr_valid & instr_ready;
  assign push   = accept & op_supported;
  assign pop    = op_valid & op_ready;

  alu_op_fifo #(
    .W     (7),
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_dat),
    .pop   (pop),
    .rdata (head_dat),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // State register. ready_en keeps intake closed during reset and opens it
  // on the first clock edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    halted      = 1'b0;
    case (state)
      RUN: begin
        instr_ready = ready_en & ~fifo_full;
        if (accept && op_is_halt) state_nxt = HALTED;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (accept && !op_supported) begin
      illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
    end else if (pop) begin
      issue_cnt <= issue_cnt + CNT_ONE;
    end
  end

  assign op_valid  = ~fifo_empty;
  assign ALU_op    = op_valid ? head_dat[6:2] : 5'b00000;
  assign ALU_funct = op_valid ? head_dat[1:0] : 2'b00;
endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        op_ready;

  logic        instr_ready;
  logic [4:0]  ALU_op;
  logic [1:0]  ALU_funct;
  logic        op_valid;
  logic        halted;
  logic        illegal;
  logic [15:0] issue_cnt;

  logic        w_instr_ready;
  logic [4:0]  w_ALU_op;
  logic [1:0]  w_ALU_funct;
  logic        w_op_valid;
  logic        w_halted;
  logic        w_illegal;
  logic [3:0]  w_issue_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_op_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .ALU_op      (ALU_op),
    .ALU_funct   (ALU_funct),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .halted      (halted),
    .illegal     (illegal),
    .issue_cnt   (issue_cnt)
  );

  alu_op_issue #(.DEPTH(2), .CNT_W(4)) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (w_instr_ready),
    .ALU_op      (w_ALU_op),
    .ALU_funct   (w_ALU_funct),
    .op_valid    (w_op_valid),
    .op_ready    (op_ready),
    .halted      (w_halted),
    .illegal     (w_illegal),
    .issue_cnt   (w_issue_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    op_ready    = 1'b0;

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_valid",    {31'd0, op_valid},    32'd0);
    chk("rst_alu_op",      {27'd0, ALU_op},      32'd0);
    chk("rst_alu_funct",   {30'd0, ALU_funct},   32'd0);
    chk("rst_halted",      {31'd0, halted},      32'd0);
    chk("rst_illegal",     {31'd0, illegal},     32'd0);
    chk("rst_issue_cnt",   {16'd0, issue_cnt},   32'd0);
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd0);

    // Release: ready only after the first rising edge.
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("rel_ready_after_edge", {31'd0, instr_ready}, 32'd1);

    // Basic issue: SUB 0xD801.
    op_ready = 1'b1; instr_valid = 1'b1; instr = 16'hD801;
    tick();
    instr_valid = 1'b0;
    chk("sub_op_valid", {31'd0, op_valid},  32'd1);
    chk("sub_alu_op",   {27'd0, ALU_op},    32'h1B);
    chk("sub_funct",    {30'd0, ALU_funct}, 32'd1);
    chk("sub_cnt_pre",  {16'd0, issue_cnt}, 32'd0);
    tick();
    chk("sub_cnt_post",  {16'd0, issue_cnt}, 32'd1);
    chk("sub_idle_vld",  {31'd0, op_valid},  32'd0);
    chk("sub_idle_op",   {27'd0, ALU_op},    32'd0);

    // Funct masking and back-to-back issue.
    instr_valid = 1'b1; instr = 16'h4003;
    tick();
    chk("addi_alu_op", {27'd0, ALU_op},    32'h08);
    chk("addi_funct",  {30'd0, ALU_funct}, 32'd0);
    instr = 16'hD801;
    tick();
    instr_valid = 1'b0;
    chk("b2b_op_valid", {31'd0, op_valid},  32'd1);
    chk("b2b_alu_op",   {27'd0, ALU_op},    32'h1B);
    chk("b2b_funct",    {30'd0, ALU_funct}, 32'd1);
    chk("b2b_cnt",      {16'd0, issue_cnt}, 32'd2);
    tick();
    chk("b2b_cnt_end",  {16'd0, issue_cnt}, 32'd3);
    chk("b2b_empty",    {31'd0, op_valid},  32'd0);

    // Backpressure with DEPTH=2.
    op_ready = 1'b0; instr_valid = 1'b1; instr = 16'h4003;
    tick();
    chk("bp_ready_1", {31'd0, instr_ready}, 32'd1);
    instr = 16'hD801;
    tick();
    chk("bp_ready_full", {31'd0, instr_ready}, 32'd0);
    instr = 16'hD000;
    tick();
    chk("bp_ready_held", {31'd0, instr_ready}, 32'd0);
    chk("bp_head_a",     {27'd0, ALU_op},      32'h08);
    chk("bp_cnt_held",   {16'd0, issue_cnt},   32'd3);
    op_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("bp_head_b",   {27'd0, ALU_op},    32'h1B);
    chk("bp_funct_b",  {30'd0, ALU_funct}, 32'd1);
    chk("bp_cnt_a",    {16'd0, issue_cnt}, 32'd4);
    tick();
    chk("bp_cnt_b",     {16'd0, issue_cnt},   32'd5);
    chk("bp_drained",   {31'd0, op_valid},    32'd0);
    chk("bp_ready_end", {31'd0, instr_ready}, 32'd1);

    // Illegal opcode 00001: dropped, sticky flag.
    instr_valid = 1'b1; instr = 16'h0800;
    tick();
    chk("ill_not_issued", {31'd0, op_valid}, 32'd0);
    chk("ill_flag",       {31'd0, illegal},  32'd1);
    instr = 16'hD801;
    tick();
    instr_valid = 1'b0;
    chk("ill_next_valid", {31'd0, op_valid}, 32'd1);
    chk("ill_next_op",    {27'd0, ALU_op},   32'h1B);
    tick();
    chk("ill_sticky", {31'd0, illegal},  32'd1);
    chk("ill_cnt",    {16'd0, issue_cnt}, 32'd6);

    // Halt: ADD, HALT, then XOR never accepted.
    instr_valid = 1'b1; instr = 16'hD000;
    tick();
    chk("halt_add_op",    {27'd0, ALU_op},    32'h1A);
    chk("halt_add_funct", {30'd0, ALU_funct}, 32'd0);
    instr = 16'h0000;
    tick();
    chk("halt_head_vld", {31'd0, op_valid},    32'd1);
    chk("halt_head_op",  {27'd0, ALU_op},      32'd0);
    chk("halt_flag",     {31'd0, halted},      32'd1);
    chk("halt_ready",    {31'd0, instr_ready}, 32'd0);
    chk("halt_cnt_add",  {16'd0, issue_cnt},   32'd7);
    instr = 16'hD002;
    tick();
    chk("halt_cnt_halt", {16'd0, issue_cnt}, 32'd8);
    chk("halt_drained",  {31'd0, op_valid},  32'd0);
    repeat (3) tick();
    chk("halt_xor_vld",   {31'd0, op_valid},  32'd0);
    chk("halt_xor_cnt",   {16'd0, issue_cnt}, 32'd8);
    chk("halt_stays",     {31'd0, halted},    32'd1);
    instr_valid = 1'b0;

    // Asynchronous reset leaves HALTED and clears flags.
    rst_n = 1'b0;
    #1;
    chk("rst2_halted",  {31'd0, halted},    32'd0);
    chk("rst2_illegal", {31'd0, illegal},   32'd0);
    chk("rst2_cnt",     {16'd0, issue_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_ready", {31'd0, instr_ready}, 32'd1);

    // Reset with two ops buffered.
    op_ready = 1'b0; instr_valid = 1'b1; instr = 16'hD801;
    tick();
    instr = 16'h4003;
    tick();
    instr_valid = 1'b0;
    chk("buf_full_vld",   {31'd0, op_valid},    32'd1);
    chk("buf_full_ready", {31'd0, instr_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_vld",   {31'd0, op_valid},    32'd0);
    chk("async_op",    {27'd0, ALU_op},      32'd0);
    chk("async_funct", {30'd0, ALU_funct},   32'd0);
    chk("async_ready", {31'd0, instr_ready}, 32'd0);
    chk("async_halt",  {31'd0, halted},      32'd0);
    tick();
    rst_n = 1'b1; op_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_no_issue", {31'd0, op_valid},  32'd0);
    chk("post_rst_cnt",      {16'd0, issue_cnt}, 32'd0);

    // Counter wrap: 17 consumptions, CNT_W=4 instance reads 1.
    instr_valid = 1'b1; instr = 16'h4003;
    repeat (17) tick();
    instr_valid = 1'b0;
    tick();
    chk("wrap_cnt16",  {16'd0, issue_cnt},   32'd17);
    chk("wrap_cnt4",   {28'd0, w_issue_cnt}, 32'd1);
    chk("wrap_empty",  {31'd0, op_valid},    32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
